// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
//
// EX/MEM pipeline stage register with a valid/ready handshake. It carries the
// execute-stage results (ALU result, store data, destination register, funct3,
// U-type result, PC+4 and the RegWrite/MemToReg/MemRead/MemWrite controls)
// into the memory stage. It supports back-pressure (stall), bubble insertion
// (flush) and an optional one-entry skid buffer.
//
// All state updates on the FALLING edge of clk, like the other pipeline
// registers of this core. rst is synchronous and active-high.
//
// Parameters
//   XLEN    data field width (alu_result, rd2, pc_plus4, utype_res)
//   REG_AW  destination register index width
//   F3_W    funct3 width
//   MTR_W   MemToReg select width
//   SKID    1 = skid entry present, in_ready comes straight from a flop
//           0 = no skid entry, in_ready = out_ready | ~out_valid
//
// Ports
//   clk, rst, flush          clock, sync reset, squash held + incoming entries
//   in_valid / in_ready      EX-side handshake
//   in_*                     EX-side fields (controls, data, wr, funct3)
//   out_valid / out_ready    MEM-side handshake
//   out_*                    registered fields; out_reg_write, out_mem_read
//                            and out_mem_write read 0 while out_valid = 0
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int F3_W   = 3,
    parameter int MTR_W  = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [MTR_W-1:0]  in_mem_to_reg,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_utype_res,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rd2,
    input  logic [REG_AW-1:0] in_wr,
    input  logic [F3_W-1:0]   in_funct3,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [MTR_W-1:0]  out_mem_to_reg,
    output logic [XLEN-1:0]   out_pc_plus4,
    output logic [XLEN-1:0]   out_utype_res,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_rd2,
    output logic [REG_AW-1:0] out_wr,
    output logic [F3_W-1:0]   out_funct3
);

    // One pipeline entry. Kept as a single packed word so the main and skid
    // registers, and the skid->main move, stay one assignment each.
    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [MTR_W-1:0]  mem_to_reg;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   utype_res;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   rd2;
        logic [REG_AW-1:0] wr;
        logic [F3_W-1:0]   funct3;
    } payload_t;

    payload_t w_in_payload;
    payload_t w_main_load_data;
    payload_t r_main_payload;

    logic     r_main_valid;
    logic     w_main_valid_next;
    logic     w_load_main;
    logic     w_in_ready;
    logic     w_in_xfer;
    logic     w_out_xfer;

    always_comb begin
        w_in_payload            = '0;
        w_in_payload.reg_write  = in_reg_write;
        w_in_payload.mem_read   = in_mem_read;
        w_in_payload.mem_write  = in_mem_write;
        w_in_payload.mem_to_reg = in_mem_to_reg;
        w_in_payload.pc_plus4   = in_pc_plus4;
        w_in_payload.utype_res  = in_utype_res;
        w_in_payload.alu_result = in_alu_result;
        w_in_payload.rd2        = in_rd2;
        w_in_payload.wr         = in_wr;
        w_in_payload.funct3     = in_funct3;
    end

    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = r_main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // EMPTY: nothing held; ONE: main only; FULL: main + skid.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t   r_state;
            state_t   w_state_next;
            payload_t r_skid_payload;
            logic     r_in_ready;
            logic     w_load_skid;
            logic     w_main_from_skid;

            // in_ready is its own flop (= ~skid_valid of the next state) so
            // EX never sees a combinational path from out_ready.
            always_ff @(negedge clk) begin
                if (rst) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_next;
                    r_in_ready <= (w_state_next != ST_FULL);
                end
            end

            always_ff @(negedge clk) begin
                if (rst) begin
                    r_skid_payload <= '0;
                end else if (w_load_skid) begin
                    r_skid_payload <= w_in_payload;
                end
            end

            always_comb begin
                w_state_next     = r_state;
                w_load_main      = 1'b0;
                w_load_skid      = 1'b0;
                w_main_from_skid = 1'b0;
                if (flush) begin
                    // Squash both entries and drop the same-edge capture.
                    w_state_next = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_xfer) begin
                                w_load_main  = 1'b1;
                                w_state_next = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_xfer && w_out_xfer) begin
                                w_load_main = 1'b1;
                            end else if (w_in_xfer) begin
                                // MEM stalled: park the new entry behind main.
                                w_load_skid  = 1'b1;
                                w_state_next = ST_FULL;
                            end else if (w_out_xfer) begin
                                w_state_next = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // in_ready is low here, so only the drain can happen;
                            // the skid entry always follows the main entry out.
                            if (w_out_xfer) begin
                                w_load_main      = 1'b1;
                                w_main_from_skid = 1'b1;
                                w_state_next     = ST_ONE;
                            end
                        end
                        default: begin
                            w_state_next = ST_EMPTY;
                        end
                    endcase
                end
            end

            assign w_in_ready        = r_in_ready;
            assign w_main_valid_next = (w_state_next != ST_EMPTY);
            assign w_main_load_data  = w_main_from_skid ? r_skid_payload : w_in_payload;
        end else begin : g_noskid
            // Without a skid entry the stage may accept only when the held
            // entry is leaving this same edge (or there is none).
            assign w_in_ready       = out_ready | ~r_main_valid;
            assign w_main_load_data = w_in_payload;

            always_comb begin
                w_main_valid_next = r_main_valid;
                w_load_main       = 1'b0;
                if (flush) begin
                    w_main_valid_next = 1'b0;
                end else if (w_in_xfer) begin
                    w_main_valid_next = 1'b1;
                    w_load_main       = 1'b1;
                end else if (w_out_xfer) begin
                    w_main_valid_next = 1'b0;
                end
            end
        end
    endgenerate

    // Main (MEM-facing) register. Reset clears every field so MEM sees an
    // all-zero bundle; flush only drops valid and leaves stale data behind.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_main_valid   <= 1'b0;
            r_main_payload <= '0;
        end else begin
            r_main_valid <= w_main_valid_next;
            if (w_load_main) begin
                r_main_payload <= w_main_load_data;
            end
        end
    end

    // Side-effecting controls are masked by valid so a bubble can never write
    // the register file or touch memory.
    logic [2:0] w_ctrl_held;
    logic [2:0] w_ctrl_gated;

    assign w_ctrl_held = {r_main_payload.reg_write,
                          r_main_payload.mem_read,
                          r_main_payload.mem_write};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ctrl_gate
            assign w_ctrl_gated[gi] = w_ctrl_held[gi] & r_main_valid;
        end
    endgenerate

    assign in_ready       = w_in_ready;
    assign out_valid      = r_main_valid;
    assign out_reg_write  = w_ctrl_gated[2];
    assign out_mem_read   = w_ctrl_gated[1];
    assign out_mem_write  = w_ctrl_gated[0];
    assign out_mem_to_reg = r_main_payload.mem_to_reg;
    assign out_pc_plus4   = r_main_payload.pc_plus4;
    assign out_utype_res  = r_main_payload.utype_res;
    assign out_alu_result = r_main_payload.alu_result;
    assign out_rd2        = r_main_payload.rd2;
    assign out_wr         = r_main_payload.wr;
    assign out_funct3     = r_main_payload.funct3;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//
// Drives one SKID=1 and one SKID=0 instance from the same EX-side inputs and
// out_ready. A queue model (capacity 2 with skid, capacity 1 without) tracks
// what each instance should hold. Inputs change and outputs are sampled just
// after the rising edge; the design updates on the falling edge.
// -----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  mtr;
        logic [31:0] pc;
        logic [31:0] ut;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
        logic [2:0]  f3;
    } ent_t;

    logic clk;
    logic rst;
    logic flush;
    logic in_valid;
    logic out_ready;
    ent_t in_e;

    logic        s_in_ready, s_valid, s_rw, s_mr, s_mw;
    logic [1:0]  s_mtr;
    logic [31:0] s_pc, s_ut, s_alu, s_rd2;
    logic [4:0]  s_wr;
    logic [2:0]  s_f3;
    logic        n_in_ready, n_valid, n_rw, n_mr, n_mw;
    logic [1:0]  n_mtr;
    logic [31:0] n_pc, n_ut, n_alu, n_rd2;
    logic [4:0]  n_wr;
    logic [2:0]  n_f3;
    ent_t        s_out, n_out;

    assign s_out = {s_rw, s_mr, s_mw, s_mtr, s_pc, s_ut, s_alu, s_rd2, s_wr, s_f3};
    assign n_out = {n_rw, n_mr, n_mw, n_mtr, n_pc, n_ut, n_alu, n_rd2, n_wr, n_f3};

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.XLEN(32), .REG_AW(5), .F3_W(3), .MTR_W(2), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_reg_write(in_e.rw), .in_mem_read(in_e.mr), .in_mem_write(in_e.mw),
        .in_mem_to_reg(in_e.mtr), .in_pc_plus4(in_e.pc), .in_utype_res(in_e.ut),
        .in_alu_result(in_e.alu), .in_rd2(in_e.rd2), .in_wr(in_e.wr), .in_funct3(in_e.f3),
        .out_valid(s_valid), .out_ready(out_ready),
        .out_reg_write(s_rw), .out_mem_read(s_mr), .out_mem_write(s_mw),
        .out_mem_to_reg(s_mtr), .out_pc_plus4(s_pc), .out_utype_res(s_ut),
        .out_alu_result(s_alu), .out_rd2(s_rd2), .out_wr(s_wr), .out_funct3(s_f3)
    );

    ex_mem_pipe_reg #(.XLEN(32), .REG_AW(5), .F3_W(3), .MTR_W(2), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_reg_write(in_e.rw), .in_mem_read(in_e.mr), .in_mem_write(in_e.mw),
        .in_mem_to_reg(in_e.mtr), .in_pc_plus4(in_e.pc), .in_utype_res(in_e.ut),
        .in_alu_result(in_e.alu), .in_rd2(in_e.rd2), .in_wr(in_e.wr), .in_funct3(in_e.f3),
        .out_valid(n_valid), .out_ready(out_ready),
        .out_reg_write(n_rw), .out_mem_read(n_mr), .out_mem_write(n_mw),
        .out_mem_to_reg(n_mtr), .out_pc_plus4(n_pc), .out_utype_res(n_ut),
        .out_alu_result(n_alu), .out_rd2(n_rd2), .out_wr(n_wr), .out_funct3(n_f3)
    );

    // ---------------- reference model: FIFO of in-flight entries ----------------
    ent_t q_s[$];
    ent_t q_n[$];
    bit   z_s = 1'b1;   // fields still all-zero since the last reset
    bit   z_n = 1'b1;
    bit   m_acc_s, m_pop_s, m_acc_n, m_pop_n;

    always @(negedge clk) begin
        if (rst) begin
            q_s.delete();
            q_n.delete();
            z_s = 1'b1;
            z_n = 1'b1;
        end else if (flush) begin
            q_s.delete();
            q_n.delete();
        end else begin
            m_acc_s = in_valid && (q_s.size() < 2);
            m_pop_s = (q_s.size() > 0) && out_ready;
            m_acc_n = in_valid && (out_ready || (q_n.size() == 0));
            m_pop_n = (q_n.size() > 0) && out_ready;
            if (m_pop_s) void'(q_s.pop_front());
            if (m_acc_s) begin
                q_s.push_back(in_e);
                z_s = 1'b0;
                $display("%0t skid   accept wr=%0d alu=%h", $time, in_e.wr, in_e.alu);
            end
            if (m_pop_n) void'(q_n.pop_front());
            if (m_acc_n) begin
                q_n.push_back(in_e);
                z_n = 1'b0;
                $display("%0t noskid accept wr=%0d alu=%h", $time, in_e.wr, in_e.alu);
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    function automatic ent_t rand_ent();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[140:0];
    endfunction

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid = 1'b1; in_e = rand_ent(); out_ready = 1'b1; rst = 1'b1;
        tick();
        in_e = rand_ent();
        tick();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL reset_n_valid got %b want 0", n_valid); end
        checks++; if (s_out !== '0) begin errors++; $display("FAIL reset_s_fields got %h want 0", s_out); end
        checks++; if (n_out !== '0) begin errors++; $display("FAIL reset_n_fields got %h want 0", n_out); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready got %b want 1", s_in_ready); end
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n_in_ready got %b want 1", n_in_ready); end
        checks++; if (s_out !== '0) begin errors++; $display("FAIL reset_idle_s_fields got %h want 0", s_out); end
    endtask

    task automatic test_stream();
        hard_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_e = rand_ent(); in_e.alu = 32'(k * 16);
            #1;
            checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL stream_s_in_ready k=%0d got %b want 1", k, s_in_ready); end
            checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL stream_n_in_ready k=%0d got %b want 1", k, n_in_ready); end
            tick();
            checks++; if (s_valid !== 1'b1 || s_alu !== 32'(k * 16)) begin errors++; $display("FAIL stream_s k=%0d got v=%b alu=%h want v=1 alu=%h", k, s_valid, s_alu, 32'(k * 16)); end
            checks++; if (n_valid !== 1'b1 || n_alu !== 32'(k * 16)) begin errors++; $display("FAIL stream_n k=%0d got v=%b alu=%h want v=1 alu=%h", k, n_valid, n_alu, 32'(k * 16)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL stream_s_drain got %b want 0", s_valid); end
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL stream_n_drain got %b want 0", n_valid); end
    endtask

    task automatic test_skid_stall();
        hard_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_e = rand_ent(); in_e.wr = 5'd5;
        tick();
        checks++; if (s_valid !== 1'b1 || s_wr !== 5'd5 || s_in_ready !== 1'b1) begin errors++; $display("FAIL stall_a got v=%b wr=%0d rdy=%b want v=1 wr=5 rdy=1", s_valid, s_wr, s_in_ready); end
        in_e = rand_ent(); in_e.wr = 5'd6;
        tick();
        checks++; if (s_in_ready !== 1'b0 || s_wr !== 5'd5) begin errors++; $display("FAIL stall_full got rdy=%b wr=%0d want rdy=0 wr=5", s_in_ready, s_wr); end
        in_e = rand_ent(); in_e.wr = 5'd7;
        tick();
        checks++; if (s_in_ready !== 1'b0 || s_wr !== 5'd5 || s_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got rdy=%b wr=%0d v=%b want rdy=0 wr=5 v=1", s_in_ready, s_wr, s_valid); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (s_valid !== 1'b1 || s_wr !== 5'd6 || s_in_ready !== 1'b1) begin errors++; $display("FAIL stall_b got v=%b wr=%0d rdy=%b want v=1 wr=6 rdy=1", s_valid, s_wr, s_in_ready); end
        tick();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got v=%b want 0", s_valid); end
    endtask

    task automatic test_flush_full();
        hard_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_e = rand_ent(); in_e.mw = 1'b1; in_e.rw = 1'b1;
        tick();
        in_e = rand_ent(); in_e.mw = 1'b1;
        tick();
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got rdy=%b want 0", s_in_ready); end
        flush = 1'b1; in_e = rand_ent(); in_e.mw = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_mw !== 1'b0 || s_rw !== 1'b0 || s_mr !== 1'b0) begin errors++; $display("FAIL flush_s got v=%b mw=%b rw=%b mr=%b want 0", s_valid, s_mw, s_rw, s_mr); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_s_in_ready got %b want 1", s_in_ready); end
        checks++; if (n_valid !== 1'b0 || n_mw !== 1'b0) begin errors++; $display("FAIL flush_n got v=%b mw=%b want 0", n_valid, n_mw); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (s_valid !== 1'b0 || n_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost k=%0d got s=%b n=%b want 0", k, s_valid, n_valid); end
        end
    endtask

    task automatic test_noskid_stall();
        ent_t x, y;
        hard_reset();
        x = rand_ent(); y = rand_ent(); y.alu = ~x.alu;
        out_ready = 1'b0; in_valid = 1'b1; in_e = x;
        tick();
        checks++; if (n_valid !== 1'b1 || n_out !== x) begin errors++; $display("FAIL nstall_load got v=%b %h want v=1 %h", n_valid, n_out, x); end
        in_e = y;
        #1;
        checks++; if (n_in_ready !== 1'b0) begin errors++; $display("FAIL nstall_in_ready got %b want 0", n_in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (n_valid !== 1'b1 || n_out !== x) begin errors++; $display("FAIL nstall_hold k=%0d got v=%b %h want %h", k, n_valid, n_out, x); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL nstall_release_rdy got %b want 1", n_in_ready); end
        tick();
        checks++; if (n_valid !== 1'b1 || n_out !== y) begin errors++; $display("FAIL nstall_next got v=%b %h want %h", n_valid, n_out, y); end
        in_valid = 1'b0;
        tick();
        checks++; if (n_valid !== 1'b0 || {n_rw, n_mr, n_mw} !== 3'b000) begin errors++; $display("FAIL nstall_empty got v=%b ctl=%b want 0", n_valid, {n_rw, n_mr, n_mw}); end
    endtask

    task automatic test_rst_flush();
        hard_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_e = rand_ent(); tick();
        in_e = rand_ent(); tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_out !== '0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL rstflush_s got v=%b %h rdy=%b want v=0 0 rdy=1", s_valid, s_out, s_in_ready); end
        checks++; if (n_valid !== 1'b0 || n_out !== '0) begin errors++; $display("FAIL rstflush_n got v=%b %h want 0", n_valid, n_out); end
        in_valid = 1'b1;
        in_e = rand_ent(); tick();
        in_e = rand_ent(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_out !== '0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL rststall_s got v=%b %h rdy=%b want v=0 0 rdy=1", s_valid, s_out, s_in_ready); end
        checks++; if (n_valid !== 1'b0 || n_out !== '0) begin errors++; $display("FAIL rststall_n got v=%b %h want 0", n_valid, n_out); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (s_valid !== (q_s.size() > 0)) begin errors++; $display("FAIL rnd_s_valid cyc=%0d got %b want %b", cyc, s_valid, q_s.size() > 0); end
            checks++; if (n_valid !== (q_n.size() > 0)) begin errors++; $display("FAIL rnd_n_valid cyc=%0d got %b want %b", cyc, n_valid, q_n.size() > 0); end
            if (q_s.size() > 0) begin
                checks++; if (s_out !== q_s[0]) begin errors++; $display("FAIL rnd_s_data cyc=%0d got %h want %h", cyc, s_out, q_s[0]); end
            end else begin
                checks++; if ({s_rw, s_mr, s_mw} !== 3'b000) begin errors++; $display("FAIL rnd_s_gate cyc=%0d got %b want 000", cyc, {s_rw, s_mr, s_mw}); end
                if (z_s) begin
                    checks++; if (s_out !== '0) begin errors++; $display("FAIL rnd_s_zero cyc=%0d got %h want 0", cyc, s_out); end
                end
            end
            if (q_n.size() > 0) begin
                checks++; if (n_out !== q_n[0]) begin errors++; $display("FAIL rnd_n_data cyc=%0d got %h want %h", cyc, n_out, q_n[0]); end
            end else begin
                checks++; if ({n_rw, n_mr, n_mw} !== 3'b000) begin errors++; $display("FAIL rnd_n_gate cyc=%0d got %b want 000", cyc, {n_rw, n_mr, n_mw}); end
                if (z_n) begin
                    checks++; if (n_out !== '0) begin errors++; $display("FAIL rnd_n_zero cyc=%0d got %h want 0", cyc, n_out); end
                end
            end
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 4);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_e      = rand_ent();
            #1;
            checks++; if (s_in_ready !== (q_s.size() < 2)) begin errors++; $display("FAIL rnd_s_in_ready cyc=%0d got %b want %b", cyc, s_in_ready, q_s.size() < 2); end
            checks++; if (n_in_ready !== (out_ready || q_n.size() == 0)) begin errors++; $display("FAIL rnd_n_in_ready cyc=%0d got %b want %b", cyc, n_in_ready, out_ready || q_n.size() == 0); end
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_e = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush_full();
        test_noskid_stall();
        test_rst_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
